// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit counter.
// Digit limits, nibble width and the load clamp live here.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Any nibble above 9 is not a decimal digit; pin it to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(
        input logic [BCD_W-1:0] n
    );
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_cnt_multi_digit.sv
// One BCD digit of the counter: holds its nibble, steps on carry/borrow in,
// and passes carry/borrow on when it rolls over in the current direction.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             ci,
    input  logic             up_dn,
    input  logic             hold,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] r_q;
    logic [BCD_W-1:0] w_step;
    logic             w_at_end;

    // At 9 going up or at 0 going down, this digit rolls over.
    assign w_at_end = up_dn ? (r_q == BCD_MAX) : (r_q == BCD_MIN);
    assign co       = ci & w_at_end;
    assign q        = r_q;

    // Next nibble for one step in the requested direction.
    always_comb begin
        w_step = r_q;
        if (up_dn)
            w_step = w_at_end ? BCD_MIN : r_q + 4'd1;
        else
            w_step = w_at_end ? BCD_MAX : r_q - 4'd1;
    end

    // Digit register: clear beats load beats a carry-driven step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_q <= BCD_MIN;
        else if (clr)
            r_q <= BCD_MIN;
        else if (ld)
            r_q <= bcd_clamp(ld_val);
        else if (ci && !hold)
            r_q <= w_step;
    end

endmodule

// File: rtl/bcd_cnt_multi.sv
// Multi-digit BCD up/down counter with load, clear and optional saturation.
// Carry/borrow ripples through the digits in one cycle; tc is the chain's end.
module bcd_cnt_multi
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                  en,
    input  logic                  up_dn,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                  tc,
    output logic                  wrapped,
    output logic                  load_err
);

    logic [DIGITS:0]   w_carry;
    logic [DIGITS-1:0] w_bad;
    logic              w_hold;
    logic              r_wrapped;
    logic              r_load_err;

    // The carry out of the top digit is exactly "enabled and every digit at
    // its end value", i.e. the terminal count.
    assign w_carry[0] = en;
    assign tc         = w_carry[DIGITS];
    assign w_hold     = SATURATE & tc;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .reset  (reset),
                .clr    (clr),
                .ld     (load),
                .ld_val (load_val[g*BCD_W +: BCD_W]),
                .ci     (w_carry[g]),
                .up_dn  (up_dn),
                .hold   (w_hold),
                .q      (count[g*BCD_W +: BCD_W]),
                .co     (w_carry[g+1])
            );
            assign w_bad[g] = load_val[g*BCD_W +: BCD_W] > BCD_MAX;
        end
    endgenerate

    // Status pulses line up with the count update they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrapped  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrapped  <= ~clr & ~load & tc;
            r_load_err <= ~clr & load & (|w_bad);
        end
    end

    assign wrapped  = r_wrapped;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_cnt_multi.sv
// Self-checking bench for bcd_cnt_multi: wrapping and saturating instances
// side by side, checked against an integer decimal reference model.
module tb_bcd_cnt_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;

    logic [15:0] count0, count1;
    logic        tc0, tc1, wr0, wr1, le0, le1;

    int n_asrt = 0;
    int n_fail = 0;

    int m_cnt[2];
    bit m_wr[2];
    bit m_le;

    always #5 clk = ~clk;

    bcd_cnt_multi #(.DIGITS(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_val(load_val), .en(en), .up_dn(up_dn),
        .count(count0), .tc(tc0), .wrapped(wr0), .load_err(le0)
    );

    bcd_cnt_multi #(.DIGITS(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .load(load),
        .load_val(load_val), .en(en), .up_dn(up_dn),
        .count(count1), .tc(tc1), .wrapped(wr1), .load_err(le1)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [15:0] lv);
        bit b;
        b = 1'b0;
        for (int i = 0; i < 4; i++)
            if (lv[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic bit model_tc(input int c, input bit e, input bit u);
        return e && (u ? (c == 9999) : (c == 0));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("count0", count0, to_bcd(m_cnt[0]));
        chk("count1", count1, to_bcd(m_cnt[1]));
        chk("wrapped0", {15'd0, wr0}, {15'd0, m_wr[0]});
        chk("wrapped1", {15'd0, wr1}, {15'd0, m_wr[1]});
        chk("load_err0", {15'd0, le0}, {15'd0, m_le});
        chk("load_err1", {15'd0, le1}, {15'd0, m_le});
    endtask

    // Called just after a falling edge: drive, check tc, clock, check state.
    task automatic step(input bit c, input bit l, input logic [15:0] lv,
                        input bit e, input bit u);
        bit t;
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
        #1;
        chk("tc0", {15'd0, tc0}, {15'd0, model_tc(m_cnt[0], e, u)});
        chk("tc1", {15'd0, tc1}, {15'd0, model_tc(m_cnt[1], e, u)});
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            t = model_tc(m_cnt[k], e, u);
            if (c) begin
                m_cnt[k] = 0;
                m_wr[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = clamp_val(lv);
                m_wr[k] = 1'b0;
            end else if (e) begin
                m_wr[k] = t;
                if (t) begin
                    if (k == 0) m_cnt[k] = u ? 0 : 9999;
                end else begin
                    m_cnt[k] = u ? m_cnt[k] + 1 : m_cnt[k] - 1;
                end
            end else begin
                m_wr[k] = 1'b0;
            end
        end
        m_le = !c && l && has_bad(lv);
        #1;
        chk_outputs();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_wr[0] = 1'b0; m_wr[1] = 1'b0;
        m_le = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        #1;
        chk_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Pending wrap pulse and a nonzero count are both killed by reset.
        step(0, 1, 16'h9999, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-count from 0123.
        step(0, 1, 16'h0123, 0, 1);
        clr = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 16'h0000, 1, 1);
        chk("after_reset_up", count0, 16'h0001);

        // Cascaded carry.
        step(0, 1, 16'h0999, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        chk("carry_chain", count0, 16'h1000);

        // Wrap up, then wrapped drops.
        step(0, 1, 16'h9999, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 0, 1);

        // Wrap down from zero.
        step(1, 0, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 1, 0);
        chk("wrap_down", count0, 16'h9999);
        step(0, 0, 16'h0000, 1, 0);

        // Saturation from 9998.
        step(0, 1, 16'h9998, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        chk("sat_hold", count1, 16'h9999);

        // Clamped and valid loads.
        step(0, 1, 16'hC3F5, 0, 1);
        chk("clamp_load", count0, 16'h9395);
        step(0, 1, 16'h1234, 0, 1);

        // Priority.
        step(1, 1, 16'h5678, 1, 1);
        step(0, 1, 16'h0042, 1, 1);
        chk("load_over_en", count0, 16'h0042);

        // Randomized traffic with boundary-biased loads.
        for (int n = 0; n < 400; n++) begin
            bit rc, rl, re, ru;
            logic [15:0] lv;
            int sel;
            rc = ($urandom_range(0, 99) < 4);
            rl = ($urandom_range(0, 99) < 15);
            re = ($urandom_range(0, 99) < 75);
            ru = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            case (sel)
                0: lv = 16'($urandom);
                1: lv = to_bcd($urandom_range(9990, 9999));
                2: lv = to_bcd($urandom_range(0, 9));
                default: lv = to_bcd($urandom_range(0, 9999));
            endcase
            step(rc, rl, lv, re, ru);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_cnt_multi.md
# bcd_cnt_multi

Parametrised multi-digit BCD counter with count-up/count-down, enable, synchronous load and clear, and optional saturation. Each decimal digit is a 4-bit BCD nibble, and carry/borrow ripples between digits within a single cycle. The block sits between timing/enable generators and display decoders. It replaces single-digit 0–9 counters wherever multi-digit decimal counts, preset values or down-counting (timers) are needed.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits (≥1); count width is 4*DIGITS.
- SATURATE, 0: 0 = wrap at the terminal count; 1 = hold at the terminal count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to all-zero.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD preset value; digit i occupies bits [4i+3:4i].
- en  in  1  count enable.
- up_dn  in  1  1 = count up, 0 = count down.
- count  out  4*DIGITS  current BCD value, registered.
- tc  out  1  combinational terminal-count indicator (see Operation).
- wrapped  out  1  registered one-cycle pulse (see Operation).
- load_err  out  1  registered one-cycle pulse on a load containing a non-BCD digit.

## Operation
- Priority per cycle: clr > load > en. With none of them asserted, count holds.
- clr: count ← 0. wrapped and load_err are 0 the next cycle.
- load: each digit of load_val above 9 is clamped to 9, and count ← the clamped value. If any digit was clamped, load_err = 1 the next cycle; otherwise 0.
- Up count (en=1, up_dn=1):
  - Digit 0 increments.
  - A digit at 9 that receives a carry goes to 0 and carries into the next digit.
  - Digit i receives a carry only when all lower digits are 9.
- Down count (en=1, up_dn=0):
  - Digit 0 decrements.
  - A digit at 0 that receives a borrow goes to 9 and borrows from the next digit.
- Terminal count:
  - tc = en & up_dn & (all digits = 9), or
  - tc = en & ~up_dn & (all digits = 0).
- On an enabled count with tc=1:
  - SATURATE=0: count wraps (99..9→00..0 going up, 00..0→99..9 going down).
  - SATURATE=1: count holds.
  - In both modes wrapped = 1 on the following cycle.
- wrapped and load_err are 0 on every cycle not listed above.
- The counter never produces a non-BCD digit. After a clamped load, every digit is ≤9 by construction.
- Changing up_dn between cycles is legal. Each cycle uses that cycle's up_dn.

## Timing
- Reset (reset=0, asynchronous): count = 0, wrapped = 0, load_err = 0. Release is synchronous to clk.
- Reset asserted mid-count or mid-load overrides immediately. No pending pulse survives reset.
- count updates one clk after the qualifying clr/load/en sample. Latency is 1 cycle.
- tc is combinational from count, en and up_dn, with no register. It is valid in the same cycle, so it can be cascaded into the en of a downstream counter.
- wrapped and load_err are 1-cycle pulses aligned with the count update they describe.
- Critical path is the carry chain across DIGITS digits. DIGITS ≤ 8 must close timing at the standard board clock.

## Structure
- Shared package `bcd_pkg`:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - BCD digit width constant = 4.
  - Clamp function for nibbles >9.
- One sub-module, `bcd_digit`:
  - Inputs: clk, reset, clr, ld, ld_val[3:0], ci (carry/borrow in), up_dn, hold.
  - Outputs: q[3:0], co.
  - Instantiated DIGITS times by a generate loop.
- The top level handles:
  - chaining co→ci;
  - global tc;
  - saturation hold (suppresses every digit's update when tc=1 and SATURATE=1);
  - the wrapped/load_err registers.

## Test plan
- Reset mid-count: DIGITS=4, count at 0123, assert reset → count=0000 asynchronously, wrapped=0, load_err=0. Release, en=1 up → 0001 next cycle.
- Cascaded carry: load 0999, en=1 up → 1000 next cycle. tc=0 throughout.
- Wrap up and down:
  - SATURATE=0, load 9999, en up: tc=1 → count=0000, wrapped=1 for exactly one cycle.
  - From 0000, en down: tc=1 → count=9999, wrapped=1.
- Saturate: SATURATE=1, load 9998, en up for 3 cycles → 9999, 9999, 9999. wrapped=0, 1, 1.
- Clamped load: load_val=4'hC,4'h3,4'hF,4'h5 (hC3F5) → count=9395, load_err=1 for one cycle. A valid load 1234 gives load_err=0.
- Priority: clr=1, load=1, en=1 together → 0000. load=1, en=1 with load_val=0042 → 0042, not 0043.
